// File: rtl/pirdsp_div_pkg.sv
// Shared types, widths and helpers for the PIRDSP sequential divider.
// Holds the FSM state type, the fixed latency and the sign-magnitude helper.
package pirdsp_div_pkg;

  localparam int DIVIDEND_WIDTH = 16;
  localparam int DIVISOR_WIDTH  = 8;
  localparam int REM_WIDTH      = DIVISOR_WIDTH + 1;
  localparam int DIV_LATENCY    = 18;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIXUP
  } div_state_e;

  // Magnitude of a value that is negative only when neg is set; v arrives
  // already sign- or zero-extended to the dividend width.
  function automatic logic [DIVIDEND_WIDTH:0] sign_mag(
    input logic [DIVIDEND_WIDTH-1:0] v,
    input logic                      neg
  );
    if (neg) return (DIVIDEND_WIDTH+1)'(0) - {v[DIVIDEND_WIDTH-1], v};
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, and keep either the difference or the shifted value.
module div_restoring_step
  import pirdsp_div_pkg::*;
(
  input  logic [REM_WIDTH-1:0] rem,
  input  logic                 bit_in,
  input  logic [REM_WIDTH-1:0] divisor,
  output logic [REM_WIDTH-1:0] rem_next,
  output logic                 q_bit
);

  logic [REM_WIDTH:0]   shifted;
  logic [REM_WIDTH+1:0] diff;
  logic                 unused_msbs;

  assign shifted = {rem, bit_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~diff[REM_WIDTH+1];

  // A kept remainder is always below the divisor, so the top bit is zero.
  assign rem_next    = q_bit ? diff[REM_WIDTH-1:0] : shifted[REM_WIDTH-1:0];
  assign unused_msbs = ^{diff[REM_WIDTH], shifted[REM_WIDTH]};

endmodule

// File: rtl/seq_divider_16by8_signed.sv
// 16-by-8 iterative restoring divider with per-operand sign modes, fixed
// 18-cycle latency, start/done handshake, overflow and divide-by-zero flags.
module seq_divider_16by8_signed
  import pirdsp_div_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] A,
  input  logic [DIVISOR_WIDTH-1:0]  B,
  input  logic                      A_sign,
  input  logic                      B_sign,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] Q,
  output logic [REM_WIDTH-1:0]      R,
  output logic                      ovf,
  output logic                      dbz
);

  div_state_e state, next_state;
  logic load_op, prep_en, iter_en, fixup_en;

  logic [DIVIDEND_WIDTH-1:0] a_reg, dvd;
  logic [DIVISOR_WIDTH-1:0]  b_reg;
  logic                      a_sgn, b_sgn, neg_a, neg_b;
  logic [REM_WIDTH-1:0]      rem, b_mag, rem_next;
  logic                      q_bit;
  logic [3:0]                cnt;
  logic [DIVIDEND_WIDTH:0]   a_full, b_full;
  logic                      unused_mag_bits;

  logic                      q_neg, signed_q, ovf_fix, b_zero;
  logic [DIVIDEND_WIDTH-1:0] q_fix;
  logic [REM_WIDTH-1:0]      r_fix;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state defaults to state first so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = PREP;
      PREP:    next_state = ITER;
      ITER:    if (cnt == 4'd15) next_state = FIXUP;
      FIXUP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    load_op  = (state == IDLE) && start;
    prep_en  = (state == PREP);
    iter_en  = (state == ITER);
    fixup_en = (state == FIXUP);
  end

  assign a_full = sign_mag(a_reg, a_sgn & a_reg[DIVIDEND_WIDTH-1]);
  assign b_full = sign_mag({{8{b_sgn & b_reg[7]}}, b_reg}, b_sgn & b_reg[7]);
  assign unused_mag_bits = ^{a_full[DIVIDEND_WIDTH], b_full[DIVIDEND_WIDTH:REM_WIDTH]};

  div_restoring_step u_step (
    .rem      (rem),
    .bit_in   (dvd[DIVIDEND_WIDTH-1]),
    .divisor  (b_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // dvd holds the unconsumed |A| bits on top and collects quotient bits below.
  assign q_neg    = neg_a ^ neg_b;
  assign signed_q = a_sgn | b_sgn;
  assign b_zero   = (b_mag == '0);
  assign q_fix    = b_zero ? '1 : (q_neg ? -dvd : dvd);
  assign r_fix    = b_zero ? '0 : (neg_a ? -rem : rem);
  assign ovf_fix  = !b_zero && (q_neg ? (dvd > 16'd32768) : (signed_q && dvd[DIVIDEND_WIDTH-1]));

  // NOTE: working registers need no reset; the FSM never reads them before
  // they are written by load/prep, so only state and outputs are reset.
  always_ff @(posedge clk) begin
    if (load_op) begin
      a_reg <= A;
      b_reg <= B;
      a_sgn <= A_sign;
      b_sgn <= B_sign;
    end
    if (prep_en) begin
      neg_a <= a_sgn & a_reg[DIVIDEND_WIDTH-1];
      neg_b <= b_sgn & b_reg[DIVISOR_WIDTH-1];
      dvd   <= a_full[DIVIDEND_WIDTH-1:0];
      b_mag <= b_full[REM_WIDTH-1:0];
      rem   <= '0;
      cnt   <= '0;
    end
    if (iter_en) begin
      rem <= rem_next;
      dvd <= {dvd[DIVIDEND_WIDTH-2:0], q_bit};
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      Q    <= '0;
      R    <= '0;
      ovf  <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      done <= fixup_en;
      if (fixup_en) begin
        Q   <= q_fix;
        R   <= r_fix;
        ovf <= ovf_fix;
        dbz <= b_zero;
      end
    end
  end

endmodule
